// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

endpackage

// File: rtl/rf_req_slot.sv
// One-entry holding register for a writeback requester: full flag plus rd/data,
// loaded on accept and cleared on drain unless refilled in the same edge.
module rf_req_slot
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [ADDR_W-1:0] load_rd,
  input  logic [DATA_W-1:0] load_data,
  output logic              full,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] data
);

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        full <= 1'b0;
    else if (load)  full <= 1'b1;
    else if (drain) full <= 1'b0;
  end

  // NOTE: the payload has no reset; it is only observed while full is set.
  always_ff @(posedge clk) begin
    if (load) begin
      rd   <= load_rd;
      data <= load_data;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin sharing of the register-file write port between ALU (A) and load (B).
// Define RF_BYPASS_EN to forward the committing write onto data1/data2.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic              busy
);

  logic              a_full, b_full;
  logic [ADDR_W-1:0] a_slot_rd, b_slot_rd;
  logic [DATA_W-1:0] a_slot_data, b_slot_data;
  logic              grant_a, grant_b;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  prio_t             prio;

  rf_req_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (a_valid && a_ready),
    .drain     (grant_a),
    .load_rd   (a_rd),
    .load_data (a_data),
    .full      (a_full),
    .rd        (a_slot_rd),
    .data      (a_slot_data)
  );

  rf_req_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (b_valid && b_ready),
    .drain     (grant_b),
    .load_rd   (b_rd),
    .load_data (b_data),
    .full      (b_full),
    .rd        (b_slot_rd),
    .data      (b_slot_data)
  );

  // Grants depend only on slot flags and prio, so ready never loops back through valid.
  assign grant_a = a_full && (!b_full || prio == PRIO_A);
  assign grant_b = b_full && (!a_full || prio == PRIO_B);

  assign a_ready = !rst && (!a_full || grant_a);
  assign b_ready = !rst && (!b_full || grant_b);
  assign busy    = a_full || b_full;

  // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
  always_comb begin
    sel_rd   = a_slot_rd;
    sel_data = a_slot_data;
    if (grant_b) begin
      sel_rd   = b_slot_rd;
      sel_data = b_slot_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio    <= PRIO_A;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (grant_a)      prio <= PRIO_B;
      else if (grant_b) prio <= PRIO_A;

      if (grant_a || grant_b) begin
        // A register-0 entry still uses its grant slot but never asserts the write.
        wr_en   <= (sel_rd != ADDR_W'(REG_ZERO));
        wr_addr <= sel_rd;
        wr_data <= sel_data;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

`ifdef RF_BYPASS_EN
  assign data1 = (wr_en && wr_addr == rs1 && rs1 != ADDR_W'(REG_ZERO)) ? wr_data : rf_data1;
  assign data2 = (wr_en && wr_addr == rs2 && rs2 != ADDR_W'(REG_ZERO)) ? wr_data : rf_data2;
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign data1     = rf_data1;
  assign data2     = rf_data2;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter; the bench itself acts as the register file.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs1, rs2;
  logic [31:0] rf_data1, rf_data2;
  logic [31:0] data1, data2;
  logic        busy;

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1(rs1), .rs2(rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .data1(data1), .data2(data2), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: two pending entries, a "who goes next" pointer, and the last commit.
  bit          m_full [2];
  logic [4:0]  m_rd   [2];
  logic [31:0] m_data [2];
  int          m_next;
  bit          m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  logic [31:0] rf_m [32];

  typedef struct {
    int          c;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;
  ent_t log_q[$];

  bit acc_a, acc_b;

  function automatic int m_pick();
    if (m_full[0] && m_full[1]) return m_next;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] rs, input logic [31:0] raw);
`ifdef RF_BYPASS_EN
    if (m_wr_en && m_wr_addr == rs && rs != 5'd0) return m_wr_data;
`endif
    return raw;
  endfunction

  task automatic model_reset();
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    m_next    = 0;
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
  endtask

  // One clock cycle: called just after a falling edge with inputs already driven.
  task automatic cycle();
    int          pick;
    bit          ra, rb;
    logic        sv_en;
    logic [4:0]  sv_addr;
    logic [31:0] sv_data;
    rf_data1 = rf_m[rs1];
    rf_data2 = rf_m[rs2];
    #1;
    pick = m_pick();
    ra   = !m_full[0] || pick == 0;
    rb   = !m_full[1] || pick == 1;
    check("a_ready", a_ready, ra);
    check("b_ready", b_ready, rb);
    check("busy", busy, m_full[0] || m_full[1]);
    check("data1", data1, exp_read(rs1, rf_data1));
    check("data2", data2, exp_read(rs2, rf_data2));
    acc_a   = a_valid && ra;
    acc_b   = b_valid && rb;
    sv_en   = wr_en;
    sv_addr = wr_addr;
    sv_data = wr_data;
    @(posedge clk);
    cyc++;
    if (sv_en) rf_m[sv_addr] = sv_data;
    if (pick >= 0) begin
      m_wr_en   = (m_rd[pick] != 5'd0);
      m_wr_addr = m_rd[pick];
      m_wr_data = m_data[pick];
      m_full[pick] = 1'b0;
      m_next    = 1 - pick;
    end else begin
      m_wr_en = 1'b0;
    end
    if (acc_a) begin m_full[0] = 1'b1; m_rd[0] = a_rd; m_data[0] = a_data; end
    if (acc_b) begin m_full[1] = 1'b1; m_rd[1] = b_rd; m_data[1] = b_data; end
    #1;
    check("wr_en", wr_en, m_wr_en);
    check("wr_addr", wr_addr, m_wr_addr);
    check("wr_data", wr_data, m_wr_data);
    if (wr_en) log_q.push_back('{cyc, wr_addr, wr_data});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int na, nb;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    model_reset();
    rst = 1'b1;
    a_valid = 0; b_valid = 0; a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
    rs1 = 0; rs2 = 0; rf_data1 = 0; rf_data2 = 0;
    #1;
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 5'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-stream with both slots full and a write on the port.
    a_valid = 1; a_rd = 1; a_data = 32'hA1;
    b_valid = 1; b_rd = 2; b_data = 32'hB2;
    for (int i = 0; i < 3; i++) cycle();
    check("mid_busy_before", busy, 1'b1);
    check("mid_wr_en_before", wr_en, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en", wr_en, 1'b0);
    check("mid_rst_a_ready", a_ready, 1'b0);
    check("mid_rst_b_ready", b_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    model_reset();
    a_valid = 0; b_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    idle(3);
    check("no_stale_write", log_q.size(), 0);

    // Contention right after reset: A first, then strict alternation, no loss.
    na = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      a_valid = 1; a_rd = 5; a_data = 100 + na;
      b_valid = 1; b_rd = 6; b_data = 200 + nb;
      cycle();
      if (acc_a) na++;
      if (acc_b) nb++;
    end
    idle(3);
    check("cont_count", log_q.size(), na + nb);
    for (int i = 0; i < log_q.size(); i++) begin
      check("cont_addr", log_q[i].addr, (i % 2) ? 5'd6 : 5'd5);
      check("cont_data", log_q[i].data, (i % 2) ? 200 + i / 2 : 100 + i / 2);
    end

    // Single requester streaming three back-to-back writes.
    log_q.delete();
    a_valid = 1; a_rd = 2; a_data = 10; cycle();
    check("single_acc0", acc_a, 1'b1);
    a_rd = 3; a_data = 20; cycle();
    check("single_acc1", acc_a, 1'b1);
    a_rd = 4; a_data = 30; cycle();
    check("single_acc2", acc_a, 1'b1);
    idle(3);
    check("single_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("single_a0", log_q[0].addr, 5'd2); check("single_d0", log_q[0].data, 32'd10);
      check("single_a1", log_q[1].addr, 5'd3); check("single_d1", log_q[1].data, 32'd20);
      check("single_a2", log_q[2].addr, 5'd4); check("single_d2", log_q[2].data, 32'd30);
      check("single_back2back", log_q[2].c - log_q[0].c, 2);
    end

    // Register 0: lone B write leaves prio on A, A's rd=0 entry then rotates it to B.
    log_q.delete();
    b_valid = 1; b_rd = 8; b_data = 32'h88; cycle();
    idle(2);
    a_valid = 1; a_rd = 0; a_data = 32'hFFFF; cycle();
    check("reg0_acc", acc_a, 1'b1);
    idle(3);
    check("reg0_one_commit", log_q.size(), 1);
    a_valid = 1; a_rd = 11; a_data = 1;
    b_valid = 1; b_rd = 12; b_data = 2;
    cycle();
    idle(3);
    check("reg0_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("reg0_first_after", log_q[1].addr, 5'd12);
      check("reg0_second_after", log_q[2].addr, 5'd11);
    end
    check("rf0_untouched", rf_m[0], 32'd0);

    // Same rd in both slots with prio on B: B commits first, A wins.
    log_q.delete();
    a_valid = 1; a_rd = 7; a_data = 40;
    b_valid = 1; b_rd = 7; b_data = 50;
    cycle();
    idle(3);
    check("same_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("same_first", log_q[0].data, 32'd50);
      check("same_second", log_q[1].data, 32'd40);
    end
    check("same_final_rf7", rf_m[7], 32'd40);

    // Bypass of the committing write onto the read outputs.
    a_valid = 1; a_rd = 9; a_data = 55; cycle();
    idle(3);
    rs1 = 9; rs2 = 0;
    a_valid = 1; a_rd = 9; a_data = 77; cycle();
    idle(1);
    rf_data1 = rf_m[9];
    rf_data2 = rf_m[0];
    #1;
    check("byp_wr_en", wr_en, 1'b1);
`ifdef RF_BYPASS_EN
    check("byp_data1", data1, 32'd77);
`else
    check("byp_data1", data1, 32'd55);
`endif
    check("byp_data2", data2, rf_data2);
    idle(2);

    // Randomized traffic with small register range to provoke collisions and rd=0.
    for (int i = 0; i < 400; i++) begin
      if (!a_valid && ($urandom % 2 == 0)) begin
        a_valid = 1; a_rd = 5'($urandom % 8); a_data = $urandom;
      end
      if (!b_valid && ($urandom % 2 == 0)) begin
        b_valid = 1; b_rd = 5'($urandom % 8); b_data = $urandom;
      end
      rs1 = 5'($urandom % 8);
      rs2 = 5'($urandom % 8);
      cycle();
      if (acc_a) a_valid = 0;
      if (acc_b) b_valid = 0;
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
